fetch_buffer: RTL and testbench

Instruction fetch front end placed between a latency-tolerant instruction memory and the hart's decode stage. It replaces the combinational `o_imem_raddr`/`i_imem_rdata` path. It issues word-aligned fetch requests over a valid/ready handshake, tracks in-flight requests, and queues returned instruction words with their PCs in a small FIFO. Decode consumes from that FIFO. Branch/jump redirects flush the queue and discard stale responses; a misaligned redirect target produces a trap entry.

---
 rtl/fetch_buffer_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/fetch_buffer.sv | 115 +++++++++++
 tb/tb_fetch_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_buffer_pkg;

  typedef enum logic {
    FB_RUN       = 1'b0,
    FB_TRAP_HOLD = 1'b1
  } fb_mode_e;

  // Default boot PC, shared with the hart.
  localparam logic [31:0] FB_RESET_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        trap;
  } fb_entry_t;

  function automatic logic is_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO with flush (push allowed in the flush cycle) and occupancy count.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      // Flush restarts at slot 0; a push in the same cycle becomes the sole entry.
      rd_ptr_q <= '0;
      wr_ptr_q <= PtrW'(push_i);
      count_q  <= CntW'(push_i);
      if (push_i) mem_q[0] <= wdata_i;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: credit-limited request issue, in-order response queueing,
// redirect flush with stale-response discard, and misaligned-target trap entries.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = FB_RESET_ADDR,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_trap
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthCnt = (CW + 1)'(DEPTH);

  fb_mode_e    mode_q;
  logic        live_q;
  logic [29:0] fetch_pc_q, fetch_pc_d;
  logic [29:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic        fifo_empty;
  logic [CW:0] credit_used;
  logic        req_fire, rsp_keep, redirect_ok, push, pop;
  fb_entry_t   wdata, rdata;

  // Queued plus in-flight words never exceed DEPTH, so every kept response has a slot.
  assign credit_used      = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign o_imem_req_valid = live_q && (mode_q == FB_RUN) && (credit_used < DepthCnt);
  assign o_imem_req_addr  = {fetch_pc_q, 2'b00};

  assign req_fire    = o_imem_req_valid && i_imem_req_ready;
  assign redirect_ok = is_aligned(i_redirect_pc);
  assign rsp_keep    = i_imem_rsp_valid && (discard_q == '0) && !i_redirect_valid;
  assign push        = rsp_keep || (i_redirect_valid && !redirect_ok);
  assign pop         = o_inst_valid && i_inst_ready && !i_redirect_valid;

  always_comb begin
    wdata = '{inst: i_imem_rsp_data, pc: {rsp_pc_q, 2'b00}, trap: 1'b0};
    if (i_redirect_valid) wdata = '{inst: 32'h0, pc: i_redirect_pc, trap: 1'b1};
  end

  always_comb begin
    inflight_d = inflight_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    if (i_redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old stream.
      discard_d = inflight_d;
    end else if (i_imem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    if (i_redirect_valid && redirect_ok) begin
      fetch_pc_d = i_redirect_pc[31:2];
      rsp_pc_d   = i_redirect_pc[31:2];
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 30'd1;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + 30'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q     <= FB_RUN;
      live_q     <= 1'b0;
      fetch_pc_q <= RESET_ADDR[31:2];
      rsp_pc_q   <= RESET_ADDR[31:2];
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      // Holds requests off until the first clock edge after reset release.
      live_q     <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      if (i_redirect_valid) mode_q <= redirect_ok ? FB_RUN : FB_TRAP_HOLD;
    end
  end

  sync_fifo #(
    .Width($bits(fb_entry_t)),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .flush_i(i_redirect_valid),
    .push_i (push),
    .wdata_i(wdata),
    .pop_i  (pop),
    .rdata_o(rdata),
    .count_o(fifo_count),
    .empty_o(fifo_empty)
  );

  assign o_inst_valid = !fifo_empty;
  assign o_inst       = rdata.inst;
  assign o_inst_pc    = rdata.pc;
  assign o_inst_trap  = rdata.trap;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: a latency-configurable memory model plus an epoch-tagged
// reference of the decode-side instruction stream.
module tb_fetch_buffer;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0100;
  localparam int unsigned DEPTH      = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_trap;

  fetch_buffer #(
    .RESET_ADDR(RESET_ADDR),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .o_imem_req_valid(o_imem_req_valid),
    .i_imem_req_ready(i_imem_req_ready),
    .o_imem_req_addr (o_imem_req_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data (i_imem_rsp_data),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_inst_valid    (o_inst_valid),
    .i_inst_ready    (i_inst_ready),
    .o_inst          (o_inst),
    .o_inst_pc       (o_inst_pc),
    .o_inst_trap     (o_inst_trap)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        trap;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  ent_t        exp_q[$];   // what decode should see, head first
  mreq_t       mem_q[$];   // accepted requests awaiting their response
  logic [31:0] next_pc;
  bit          run;
  int          epoch;
  int          cyc;
  int          lat_min, lat_max;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit model_req_valid();
    return run && ((exp_q.size() + mem_q.size()) < int'(DEPTH));
  endfunction

  function automatic bit rsp_due();
    return (mem_q.size() != 0) && (mem_q[0].due <= cyc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive_idle();
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = 32'h0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'h0;
    i_inst_ready     = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mem_q.delete();
    next_pc = RESET_ADDR;
    run     = 1'b1;
    epoch++;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
    bit    exp_rv, fire, rsp;
    int    due;
    mreq_t m;
    exp_rv = model_req_valid();
    chk("inst_valid", o_inst_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("inst_pc", o_inst_pc, exp_q[0].pc);
      chk("inst_word", o_inst, exp_q[0].inst);
      chk("inst_trap", o_inst_trap, exp_q[0].trap);
    end
    chk("req_valid", o_imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", o_imem_req_addr, next_pc);

    rsp = rsp_due();
    i_imem_req_ready = rdy;
    i_inst_ready     = irdy;
    i_redirect_valid = redir;
    i_redirect_pc    = rpc;
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data  = rsp ? inst_of(mem_q[0].addr) : $urandom;

    fire = exp_rv && rdy;
    if ((exp_q.size() != 0) && irdy && !redir) void'(exp_q.pop_front());
    if (rsp) begin
      m = mem_q.pop_front();
      if ((m.epoch == epoch) && !redir) exp_q.push_back('{inst_of(m.addr), m.addr, 1'b0});
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if ((mem_q.size() != 0) && (due <= mem_q[$].due)) due = mem_q[$].due + 1;
      m.addr  = next_pc;
      m.epoch = epoch;
      m.due   = due;
      mem_q.push_back(m);
      next_pc = next_pc + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      if (rpc[1:0] == 2'b00) begin
        next_pc = rpc;
        run     = 1'b1;
      end else begin
        exp_q.push_back('{32'h0, rpc, 1'b1});
        run = 1'b0;
      end
    end
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic release_reset();
    drive_idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    chk("first_req_valid", o_imem_req_valid, 1'b1);
    chk("first_req_addr", o_imem_req_addr, RESET_ADDR);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    bit          redir;
    logic [31:0] rpc;
    epoch   = 0;
    cyc     = 0;
    lat_min = 1;
    lat_max = 1;
    i_rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);

    chk("rst_req_valid", o_imem_req_valid, 1'b0);
    chk("rst_inst_valid", o_inst_valid, 1'b0);
    chk("rst_inst_trap", o_inst_trap, 1'b0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_inst_pc", o_inst_pc, 32'h0);
    chk("rst_req_addr", o_imem_req_addr, RESET_ADDR);
    release_reset();

    // Streaming with a 1-cycle memory and an always-ready decode.
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stalled: requests stop once queue plus in-flight reaches DEPTH.
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_no_req", o_imem_req_valid, 1'b0);
    chk("stall_full_valid", o_inst_valid, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // 3-cycle memory, redirect to 0x200 with exactly two requests in flight.
    lat_min = 3;
    lat_max = 3;
    step(1'b1, 1'b1, 1'b1, 32'h180);
    n = 0;
    while ((mem_q.size() != 2) && (n < 100)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("two_inflight_reached", n < 100, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    n = 0;
    while ((exp_q.size() == 0) && (n < 50)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("first_pc_after_redirect", o_inst_pc, 32'h200);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with both a response and a request fire.
    lat_min = 2;
    lat_max = 2;
    n = 0;
    while (!(model_req_valid() && rsp_due()) && (n < 100)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("collision_reached", n < 100, 1'b1);
    step(1'b1, 1'b1, 1'b1, 32'h280);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned target: one trap entry, fetch held until the next redirect.
    step(1'b1, 1'b1, 1'b1, 32'h202);
    chk("trap_valid", o_inst_valid, 1'b1);
    chk("trap_pc", o_inst_pc, 32'h202);
    chk("trap_inst", o_inst, 32'h0);
    chk("trap_flag", o_inst_trap, 1'b1);
    chk("trap_no_req", o_imem_req_valid, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("trap_hold_no_req", o_imem_req_valid, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    chk("resume_req_valid", o_imem_req_valid, 1'b1);
    chk("resume_req_addr", o_imem_req_addr, 32'h300);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Fetch PC wraps past the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic: variable latency, backpressure and redirects.
    lat_min = 1;
    lat_max = 4;
    repeat (2000) begin
      redir = ($urandom_range(99, 0) < 4);
      rpc   = ($urandom & 32'h0000_0FFC) |
              (($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 1)) : 32'h0);
      step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, redir, rpc);
    end

    // Asynchronous reset with three entries queued.
    lat_min = 1;
    lat_max = 1;
    step(1'b1, 1'b1, 1'b1, 32'h400);
    n = 0;
    while ((exp_q.size() != 3) && (n < 50)) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("three_queued_reached", n < 50, 1'b1);
    chk("pre_reset_valid", o_inst_valid, 1'b1);
    #2;
    i_rst_n = 1'b0;
    drive_idle();
    #1;
    chk("async_rst_inst_valid", o_inst_valid, 1'b0);
    chk("async_rst_req_valid", o_imem_req_valid, 1'b0);
    chk("async_rst_inst_pc", o_inst_pc, 32'h0);
    chk("async_rst_req_addr", o_imem_req_addr, RESET_ADDR);
    model_reset();
    release_reset();
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
